// File: rtl/key_irq_ctrl.sv
// rtl/key_irq_ctrl.sv - debounced button interrupt source with a vectored level irq
// Define KEY_REPEAT_EN to build the per-key auto-repeat logic.
module key_irq_ctrl #(
   parameter int NUM_KEYS       = 3,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int REPEAT_DELAY   = 32,
   parameter int REPEAT_RATE    = 8,
   parameter int VEC_BASE       = 2,
   parameter int VEC_STEP       = 2
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                tick_en,
   input  logic [NUM_KEYS-1:0] btn_n,
   input  logic                irq_mask,
   input  logic                irq_ack,
   output logic                irq,
   output logic [7:0]          vector,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] pending
);
   localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   if (NUM_KEYS < 1 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("key_irq_ctrl: NUM_KEYS, DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE must be >= 1");
   end

   typedef enum logic {A_IDLE, A_REQ} arb_t;

   arb_t                arb_q;
   logic [NUM_KEYS-1:0] sync1_q, sync2_q, pressed_q, pending_q, pending_d;
   logic [DW-1:0]       dcnt_q [NUM_KEYS];
   logic [KW-1:0]       key_q, sel;
   logic [7:0]          vector_q;
   logic                irq_q;
   logic [NUM_KEYS-1:0] toggle, press_ev, rep_ev, clr;

   always_comb begin
      toggle   = '0;
      press_ev = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         toggle[i]   = tick_en && (sync2_q[i] != pressed_q[i]) &&
                       (dcnt_q[i] == DW'(DEBOUNCE_TICKS - 1));
         press_ev[i] = toggle[i] && !pressed_q[i];
      end
   end

   // sync2_q is already inverted, so it is the active-high key level
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         pressed_q <= '0;
         for (int i = 0; i < NUM_KEYS; i++) dcnt_q[i] <= '0;
      end else begin
         sync1_q <= ~btn_n;
         sync2_q <= sync1_q;
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync2_q[i] == pressed_q[i]) begin
               dcnt_q[i] <= '0;
            end else if (tick_en) begin
               if (toggle[i]) begin
                  dcnt_q[i]    <= '0;
                  pressed_q[i] <= ~pressed_q[i];
               end else begin
                  dcnt_q[i] <= dcnt_q[i] + DW'(1);
               end
            end
         end
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_t;

   rep_t          rep_q  [NUM_KEYS];
   logic [RW-1:0] rcnt_q [NUM_KEYS];

   always_comb begin
      rep_ev = '0;
      for (int i = 0; i < NUM_KEYS; i++)
         rep_ev[i] = tick_en && pressed_q[i] && (rep_q[i] != R_IDLE) && (rcnt_q[i] == '0);
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            rep_q[i]  <= R_IDLE;
            rcnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (press_ev[i]) begin
               rep_q[i]  <= R_DELAY;
               rcnt_q[i] <= RW'(REPEAT_DELAY - 1);
            end else if (!pressed_q[i]) begin
               rep_q[i] <= R_IDLE;
            end else if (tick_en && rep_q[i] != R_IDLE) begin
               if (rcnt_q[i] == '0) begin
                  rep_q[i]  <= R_REPEAT;
                  rcnt_q[i] <= RW'(REPEAT_RATE - 1);
               end else begin
                  rcnt_q[i] <= rcnt_q[i] - RW'(1);
               end
            end
         end
      end
   end
`else
   assign rep_ev = '0;
`endif

   // A new event in the same clock as the ack re-sets the bit: set wins
   always_comb begin
      sel = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (pending_q[i]) sel = KW'(i);
      clr = '0;
      if (arb_q == A_REQ && irq_ack) clr = NUM_KEYS'(1) << key_q;
      pending_d = (pending_q & ~clr) | press_ev | rep_ev;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         arb_q     <= A_IDLE;
         irq_q     <= 1'b0;
         vector_q  <= 8'(VEC_BASE);
         key_q     <= '0;
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
         case (arb_q)
            A_IDLE: if (pending_q != '0 && !irq_mask) begin
               key_q    <= sel;
               vector_q <= 8'(VEC_BASE + VEC_STEP * int'(sel));
               irq_q    <= 1'b1;
               arb_q    <= A_REQ;
            end
            A_REQ: if (irq_ack) begin
               irq_q <= 1'b0;
               arb_q <= A_IDLE;
            end
            default: arb_q <= A_IDLE;
         endcase
      end
   end

   assign irq     = irq_q;
   assign vector  = vector_q;
   assign pressed = pressed_q;
   assign pending = pending_q;
endmodule

// File: tb/tb_key_irq_ctrl.sv
// tb/tb_key_irq_ctrl.sv - randomized scoreboard bench for key_irq_ctrl
// Reference model works in tick counts per key; scoreboard holds expected vectors.
`timescale 1ns/1ps
module tb_key_irq_ctrl;
   localparam int NK = 3, DT = 4, RD = 32, RR = 8, VB = 2, VS = 2;

   logic          clock = 1'b0, rst = 1'b1, tick_en = 1'b1, irq_mask = 1'b0, irq_ack = 1'b0;
   logic [NK-1:0] btn_n = '0;
   logic          irq;
   logic [7:0]    vector;
   logic [NK-1:0] pressed, pending;

   int   checks = 0, failures = 0, cyc = 0;
   logic auto_ack = 1'b0, man_ack = 1'b0;

   logic [NK-1:0] m_s1, m_s2, m_pressed, m_pending;
   int            m_run [NK];
   int            m_held[NK];
   logic          m_req;
   int            m_k;
   logic [7:0]    m_vec;
   logic [7:0]    exp_q[$];

   key_irq_ctrl #(.NUM_KEYS(NK), .DEBOUNCE_TICKS(DT), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                  .VEC_BASE(VB), .VEC_STEP(VS)) dut (
      .clock(clock), .rst(rst), .tick_en(tick_en), .btn_n(btn_n), .irq_mask(irq_mask),
      .irq_ack(irq_ack), .irq(irq), .vector(vector), .pressed(pressed), .pending(pending));

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_ack();
      man_ack = 1'b1;
      clk(1);
      man_ack = 1'b0;
   endtask

   task automatic wait_irq(input int max_c, input string name);
      int n = 0;
      while (!irq && n < max_c) begin
         clk(1);
         n++;
      end
      chk({name, "_timeout"}, irq, 1);
   endtask

   function automatic void model_clear();
      m_s1 = '0; m_s2 = '0; m_pressed = '0; m_pending = '0;
      m_req = 1'b0; m_k = 0; m_vec = 8'(VB);
      for (int i = 0; i < NK; i++) begin
         m_run[i]  = 0;
         m_held[i] = 0;
      end
      exp_q.delete();
   endfunction

   // Reference model: advances on each rising edge from the inputs seen there
   initial begin
      logic [NK-1:0] old_p, old_pend, ev, clr;
      model_clear();
      forever begin
         @(posedge clock or negedge rst);
         if (!rst) begin
            model_clear();
         end else begin
            old_p = m_pressed; old_pend = m_pending; ev = '0; clr = '0;
            for (int i = 0; i < NK; i++) begin
               if (m_s2[i] == old_p[i]) m_run[i] = 0;
               else if (tick_en) begin
                  m_run[i]++;
                  if (m_run[i] == DT) begin
                     m_run[i] = 0;
                     m_pressed[i] = ~old_p[i];
                     if (!old_p[i]) begin
                        ev[i] = 1'b1;
                        m_held[i] = 0;
                     end
                  end
               end
`ifdef KEY_REPEAT_EN
               if (old_p[i] && tick_en) begin
                  m_held[i]++;
                  if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RR == 0)) ev[i] = 1'b1;
               end
`endif
            end
            if (m_req) begin
               if (irq_ack) begin
                  clr[m_k] = 1'b1;
                  m_req = 1'b0;
               end
            end else if (old_pend != '0 && !irq_mask) begin
               for (int i = NK - 1; i >= 0; i--) if (old_pend[i]) m_k = i;
               m_req = 1'b1;
               m_vec = 8'((VB + VS * m_k) % 256);
               exp_q.push_back(m_vec);
            end
            m_pending = (old_pend & ~clr) | ev;
            m_s2 = m_s1;
            m_s1 = ~btn_n;
         end
      end
   end

   // Ack driver: random in auto mode, otherwise follows man_ack
   initial begin
      forever begin
         @(posedge clock);
         cyc++;
         #2;
         irq_ack = auto_ack ? ($urandom_range(0, 2) == 0) : man_ack;
      end
   end

   // Monitor: compares levels every cycle, pops the scoreboard on each irq rise
   initial begin
      logic       prev_irq;
      logic [7:0] e;
      prev_irq = 1'b0;
      forever begin
         @(negedge clock);
         if (rst) begin
            chk("irq_level", irq, m_req);
            chk("pressed", pressed, m_pressed);
            chk("pending", pending, m_pending);
            if (irq && !prev_irq) begin
               if (exp_q.size() == 0) chk("unexpected_irq_vector", vector, -1);
               else begin
                  e = exp_q.pop_front();
                  chk("sb_vector", vector, e);
               end
            end
         end
         prev_irq = irq;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises[$];
      int exp_rises[$];
      int t0, cur, k;
      logic last;

      #1 rst = 1'b0;
      clk(5);
      chk("rst_irq", irq, 0);
      chk("rst_vector", vector, VB);
      chk("rst_pressed", pressed, 0);
      chk("rst_pending", pending, 0);
      btn_n = '1;
      rst = 1'b1;
      clk(10);
      chk("post_rst_irq", irq, 0);
      chk("post_rst_vector", vector, VB);
      chk("post_rst_pending", pending, 0);

      for (int ph = 0; ph < 10; ph++) begin
         btn_n[0] = (ph % 2 == 1);
         clk(2);
         chk("bounce_pressed0", pressed[0], 0);
      end
      btn_n[0] = 1'b0;
      clk(6);
      chk("deb_irq_early", irq, 0);
      clk(1);
      chk("deb_irq", irq, 1);
      chk("deb_vector", vector, VB);
      chk("deb_pressed0", pressed[0], 1);
      do_ack();
      btn_n = '1;
      clk(10);

      btn_n = 3'b001;
      wait_irq(20, "prio");
      chk("prio_vec_first", vector, VB + VS);
      chk("prio_pending", pending, 3'b110);
      do_ack();
      chk("prio_gap", irq, 0);
      clk(1);
      chk("prio_second_irq", irq, 1);
      chk("prio_vec_second", vector, VB + 2 * VS);
      do_ack();
      clk(3);
      chk("prio_done_irq", irq, 0);
      chk("prio_done_pending", pending, 0);
      btn_n = '1;
      clk(10);

      irq_mask = 1'b1;
      btn_n = 3'b110;
      clk(10);
      chk("mask_pending", pending, 3'b001);
      chk("mask_irq", irq, 0);
      irq_mask = 1'b0;
      clk(1);
      chk("unmask_irq", irq, 1);
      chk("unmask_vector", vector, VB);
      btn_n = '1;
      do_ack();
      clk(10);

      btn_n = 3'b110;
      wait_irq(20, "coal");
      btn_n = 3'b111; clk(8);
      btn_n = 3'b101; clk(8);
      chk("coal_pending_a", pending, 3'b011);
      btn_n = 3'b111; clk(8);
      btn_n = 3'b101; clk(8);
      chk("coal_pending_b", pending, 3'b011);
      chk("coal_vector_held", vector, VB);
      btn_n = 3'b111; clk(8);
      do_ack();
      clk(1);
      chk("coal_vec_key1", vector, VB + VS);
      do_ack();
      clk(10);
      chk("coal_single_irq", irq, 0);
      chk("coal_single_pending", pending, 0);

      btn_n = 3'b110;
      wait_irq(20, "rep");
      chk("rep_first_vec", vector, VB);
      t0 = cyc; cur = 0; last = 1'b1;
      rises.push_back(0);
      for (int c = 0; c < 62; c++) begin
         man_ack = irq && (cur != RD + RR || cyc - t0 == RD + 2 * RR - 2);
         clk(1);
         if (irq && !last) begin
            cur = cyc - t0;
            rises.push_back(cur);
         end
         last = irq;
      end
      man_ack = 1'b0;
      exp_rises.push_back(0);
`ifdef KEY_REPEAT_EN
      for (int r = RD; r <= 60; r += RR) exp_rises.push_back(r);
`endif
      chk("rep_count", rises.size(), exp_rises.size());
      for (int i = 0; i < exp_rises.size() && i < rises.size(); i++)
         chk("rep_offset", rises[i], exp_rises[i]);
      btn_n = '1;
      auto_ack = 1'b1;
      clk(20);

      btn_n = 3'b011;
      auto_ack = 1'b0;
      clk(2);
      wait_irq(20, "midrst");
      rst = 1'b0;
      #1;
      chk("midrst_irq", irq, 0);
      chk("midrst_pending", pending, 0);
      chk("midrst_pressed", pressed, 0);
      chk("midrst_vector", vector, VB);
      btn_n = '1;
      clk(3);
      rst = 1'b1;
      clk(5);

      auto_ack = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 11) == 0) begin
            k = $urandom_range(0, NK - 1);
            btn_n[k] = ~btn_n[k];
         end
         if ($urandom_range(0, 39) == 0) irq_mask = ~irq_mask;
         clk(1);
      end
      irq_mask = 1'b0;
      tick_en = 1'b1;
      btn_n = '1;
      clk(200);
      auto_ack = 1'b0;
      clk(5);
      chk("end_queue_empty", exp_q.size(), 0);
      chk("end_irq", irq, 0);
      chk("end_pending", pending, 0);
      chk("end_pressed", pressed, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/key_irq_ctrl.md
Name: key_irq_ctrl

Overview:
- Front-end interrupt source for the 8-bit CPU: the initiator side of the button-interrupt interface that the CPU core responds to.
- Synchronises and debounces raw active-low buttons, with optional key auto-repeat.
- Latches one pending event per key and raises a level interrupt request with a fixed vector address (2/4/6 by default). The request is held until the core acknowledges it.
- Also exports the debounced key level for the core's button register.

Parameters:
- NUM_KEYS, 3, number of interrupt-capable keys; index 0 has highest priority.
- DEBOUNCE_TICKS, 4, consecutive ticks a new level must hold before it is accepted.
- REPEAT_DELAY, 32, ticks from press to the first repeat event.
- REPEAT_RATE, 8, ticks between subsequent repeat events.
- VEC_BASE, 2, vector address for key 0.
- VEC_STEP, 2, vector address increment per key index.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick_en  in  1  one-clock timing strobe for debounce and repeat counters.
- btn_n  in  NUM_KEYS  raw buttons, active-low, asynchronous to clock.
- irq_mask  in  1  1 = no new request is issued (core's di flag).
- irq_ack  in  1  one-clock pulse from the core when it takes the vector.
- irq  out  1  interrupt request, level.
- vector  out  8  vector address, valid while irq=1.
- pressed  out  NUM_KEYS  debounced key level, 1 = held.
- pending  out  NUM_KEYS  latched, not-yet-serviced events.

Behaviour:
- Reset: irq=0, vector=VEC_BASE, pressed=0, pending=0. All synchronisers, counters and repeat states clear. Arbiter goes to IDLE. Reset mid-request drops irq immediately and loses pending events.
- Synchroniser: 2-flop per key, inverted, giving active-high s[i].
- Debounce, per key:
  - Counter advances only on tick_en while s[i]!=pressed[i].
  - Counter clears on any clock where s[i]==pressed[i].
  - On the tick where the counter reaches DEBOUNCE_TICKS-1, pressed[i] toggles and the counter clears.
  - Counter width is clog2(DEBOUNCE_TICKS).
- Press event: a pressed[i] 0->1 transition sets pending[i] in the same clock as the toggle. Release produces no event.
- Repeat FSM, per key (KEY_REPEAT_EN only):
  - R_IDLE -> R_DELAY on press; counter loads REPEAT_DELAY-1.
  - R_DELAY: counter decrements on tick_en. At 0, set pending[i], load REPEAT_RATE-1, go R_REPEAT.
  - R_REPEAT: same decrement. At 0, set pending[i] and reload.
  - pressed[i]=0 in any state -> R_IDLE.
  - Release does not clear an already-set pending[i].
- Coalescing: events for a key whose pending bit is already set are absorbed; there is no count.
- Arbiter FSM:
  - A_IDLE: if pending!=0 and irq_mask=0, select the lowest set index k. Next clock: vector=VEC_BASE+VEC_STEP*k (8-bit, wraps mod 256), irq=1, go A_REQ.
  - A_REQ: irq and vector held stable regardless of irq_mask or new events. On irq_ack=1: clear pending[k], irq=0 next clock, go A_IDLE.
  - irq is low for at least one clock between requests.
  - irq_ack in A_IDLE is ignored.
- Simultaneous events:
  - Ack and a new event for key k in the same clock: the set wins, so pending[k] stays 1.
  - Multiple keys pending: serviced one per request in index order.
  - A higher-priority key arriving during A_REQ does not pre-empt the current request.
- Latency, with tick_en=1 every clock: an irq rising edge follows a clean btn_n fall by 2 sync + DEBOUNCE_TICKS + 1 clocks = 7 clocks with defaults.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined: the per-key repeat FSM and its counters are built; holding a key generates an event after REPEAT_DELAY ticks and then every REPEAT_RATE ticks.
- Undefined: no repeat logic is built; only press edges set pending; REPEAT_DELAY and REPEAT_RATE are unused.

Test Plan:
- Reset: hold rst=0 with btn_n=000 -> irq=0, vector=2, pressed=0, pending=0; still so 10 clocks after release with btn_n=111.
- Debounce: tick_en=1; btn_n[0] bounces 0/1 every 2 clocks for 20 clocks, then holds 0 -> pressed[0] stays 0 during bounce; pressed[0]=1 and irq=1 with vector=2 at 7 clocks after the final fall.
- Handshake and priority: press keys 2 and 1 together -> vector=4 first. Ack -> irq low 1 clock, then vector=6. Ack -> pending=0, irq stays 0.
- Mask: irq_mask=1 and press key 0 -> pending[0]=1, irq=0. Drop mask -> irq=1, vector=2 next clock.
- Coalesce and collision: key 1 pending during A_REQ for key 0; re-press key 1 -> one request only (vector=4). A repeat event coinciding with ack -> pending stays set and a second request follows.
- Repeat (KEY_REPEAT_EN, tick_en=1): hold key 0 for 60 clocks, acking each request -> requests at press+0, press+32, press+40, press+48, press+56. Without the macro -> one request only.
